// File: rtl/maple_frame_checker.sv
// Maple Bus frame checker: forwards RX bytes through a register slice,
// flags header/length/XOR errors on tlast and keeps good/bad frame counters.
module maple_frame_checker #(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_MAX_WORDS        = 255,
    parameter int C_COUNT_WIDTH      = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic                          enable,
    input  logic                          clear_counts,
    output logic [3:0]                    status,
    output logic                          status_valid,
    output logic [C_COUNT_WIDTH-1:0]      frame_ok_count,
    output logic [C_COUNT_WIDTH-1:0]      frame_err_count
);

    typedef enum logic [1:0] {HDR, PAYLOAD, CHECK, DROP} state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] xor_q, xor_d;
    logic [9:0] rem_q, rem_d;
    logic       len_err_q, len_err_d;
    logic       bypass_q, bypass_d;

    logic       accept;
    logic       byp;
    logic       fwd;
    logic       out_last;
    logic       out_user;
    logic       done;
    logic [3:0] errs;
    logic       len_now;
    logic [7:0] b;

    assign b = s_axis_tdata[7:0];
    assign s_axis_tready = (state_q == DROP) ? 1'b1
                         : (!m_axis_tvalid || m_axis_tready);
    assign accept = s_axis_tvalid && s_axis_tready;
    // Bypass decision is made only on the first byte of a frame.
    assign byp = bypass_q || (state_q == HDR && idx_q == 2'd0 && !enable);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        rem_d     = rem_q;
        len_err_d = len_err_q;
        bypass_d  = bypass_q;
        fwd       = 1'b0;
        out_last  = 1'b0;
        out_user  = 1'b0;
        done      = 1'b0;
        errs      = 4'b0000;
        len_now   = len_err_q;
        if (accept) begin
            if (byp) begin
                fwd      = 1'b1;
                out_last = s_axis_tlast;
                bypass_d = !s_axis_tlast;
            end else begin
                unique case (state_q)
                    HDR: begin
                        fwd   = 1'b1;
                        xor_d = xor_q ^ b;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd0) begin
                            xor_d   = b;
                            rem_d   = {b, 2'b00};
                            len_now = int'(b) > C_MAX_WORDS;
                        end
                        len_err_d = len_now;
                        if (s_axis_tlast) begin
                            done     = 1'b1;
                            errs     = {len_now, 1'b1, 2'b00};
                            out_last = 1'b1;
                            out_user = 1'b1;
                            idx_d    = 2'd0;
                            xor_d    = 8'h00;
                        end else if (idx_q == 2'd3) begin
                            state_d = (rem_q == 10'd0) ? CHECK : PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        fwd   = 1'b1;
                        xor_d = xor_q ^ b;
                        rem_d = rem_q - 10'd1;
                        if (s_axis_tlast) begin
                            done     = 1'b1;
                            errs     = {len_err_q, 1'b1, 2'b00};
                            out_last = 1'b1;
                            out_user = 1'b1;
                            state_d  = HDR;
                            idx_d    = 2'd0;
                            xor_d    = 8'h00;
                        end else if (rem_q == 10'd1) begin
                            state_d = CHECK;
                        end
                    end
                    CHECK: begin
                        fwd      = 1'b1;
                        out_last = 1'b1;
                        done     = 1'b1;
                        errs     = {len_err_q, 1'b0, !s_axis_tlast,
                                    (xor_q ^ b) != 8'h00};
                        out_user = |errs;
                        xor_d    = 8'h00;
                        idx_d    = 2'd0;
                        state_d  = s_axis_tlast ? HDR : DROP;
                    end
                    DROP: begin
                        if (s_axis_tlast) begin
                            state_d = HDR;
                            idx_d   = 2'd0;
                        end
                    end
                    default: state_d = HDR;
                endcase
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= HDR;
            idx_q           <= 2'd0;
            xor_q           <= 8'h00;
            rem_q           <= 10'd0;
            len_err_q       <= 1'b0;
            bypass_q        <= 1'b0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            status          <= 4'b0000;
            status_valid    <= 1'b0;
            frame_ok_count  <= '0;
            frame_err_count <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            rem_q     <= rem_d;
            len_err_q <= len_err_d;
            bypass_q  <= bypass_d;
            if (fwd) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= out_last;
                m_axis_tuser  <= out_user;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            status_valid <= done;
            if (done) begin
                status <= errs;
            end
            // A clear in the completion cycle swallows that frame's increment.
            if (clear_counts) begin
                frame_ok_count  <= '0;
                frame_err_count <= '0;
            end else if (done) begin
                if (|errs) begin
                    if (frame_err_count != '1)
                        frame_err_count <= frame_err_count + 1'b1;
                end else begin
                    if (frame_ok_count != '1)
                        frame_ok_count <= frame_ok_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/maple_frame_checker.md
Name: maple_frame_checker

Overview:
Streaming checker directly downstream of the Maple Bus RX FIFO master port, between the FIFO and the DMA/AXIS consumer. Parses each received byte stream as a Maple Bus frame: 4-byte header, then 4*N payload bytes, then one XOR check byte. It forwards every byte through a one-stage register slice. It marks frame boundaries and errors on the output stream, discards overrun bytes, and keeps saturating good/bad frame counters for the control register block.

Parameters:
C_AXIS_TDATA_WIDTH, 8, stream data width; only 8 is supported.
C_MAX_WORDS, 255, largest legal header length field in 32-bit words.
C_COUNT_WIDTH, 16, width of the frame counters.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axis_tdata  in  8  byte from the RX FIFO
s_axis_tlast  in  1  end of received packet
s_axis_tvalid  in  1  input byte valid
s_axis_tready  out  1  input byte accepted
m_axis_tdata  out  8  forwarded byte
m_axis_tlast  out  1  end of checked frame
m_axis_tuser  out  1  frame error, meaningful only on the tlast beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
enable  in  1  0 = pure pass-through (tuser=0, no checking, counters frozen)
clear_counts  in  1  one-cycle pulse that zeroes both counters
status  out  4  error bits of the last completed frame: {len_err, short, long, crc}
status_valid  out  1  one-cycle pulse when status updates
frame_ok_count  out  C_COUNT_WIDTH  saturating count of good frames
frame_err_count  out  C_COUNT_WIDTH  saturating count of bad frames

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - m_axis_tvalid=0, tdata=0, tlast=0, tuser=0.
  - status=0, status_valid=0, both counters=0.
  - FSM returns to HDR; the running XOR and byte counter clear.
  - A partially forwarded frame is abandoned; no tlast is emitted for it.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready, except in DROP state, where it is 1.
  - Input beat accepted when s_axis_tvalid && s_axis_tready.
  - Latency input to output is 1 cycle; full throughput of 1 byte per cycle.
  - Output holds stable while m_axis_tvalid && !m_axis_tready.
- Header and check byte:
  - Header byte order: byte0 = length N (words), byte1 = sender, byte2 = recipient, byte3 = command.
  - Check byte = XOR of all preceding frame bytes; a correct frame has XOR of all bytes including the check byte equal to 0.
- FSM states: HDR (byte index 0..3), PAYLOAD, CHECK, DROP.
  - HDR: latch N from byte0 and set expected payload bytes to 4*N (10-bit).
    - N > C_MAX_WORDS sets len_err; checking continues with 4*N as the expected payload.
    - After byte3: go to CHECK if N=0, else PAYLOAD.
  - PAYLOAD: decrement the remaining count on each accepted byte; the last payload byte moves to CHECK.
  - CHECK: the accepted byte is forwarded with m_axis_tlast=1.
    - crc = (running XOR ^ byte) != 0.
    - If s_axis_tlast=0, set long and go to DROP; otherwise go to HDR.
  - DROP: accept and discard bytes with no output; on a beat with s_axis_tlast=1, go to HDR.
- Early tlast: s_axis_tlast in HDR or PAYLOAD sets short and forwards that byte with tlast=1. The crc bit is not evaluated. Return to HDR.
- Frame completion, on the cycle the tlast beat is accepted into the output register:
  - m_axis_tuser = OR of the error bits.
  - status updates and status_valid pulses for 1 cycle.
  - Exactly one counter increments, saturating at all-ones.
  - If clear_counts occurs in the same cycle, clear wins and the increment is lost.
- enable is sampled only in HDR at byte index 0.
  - A change mid-frame takes effect at the next frame.
  - Disabled frames pass with input tlast, tuser=0, no status pulse, no count.

Test Plan:
- Frame 03 01 20 01 + 12 payload bytes (0x00..0x0B) + correct XOR, tlast on the last byte, m_tready=1 → 17 output bytes; tlast and tuser=0 on byte 17; status=0000; frame_ok_count=1.
- Same frame with the check byte XOR 0x01 → tuser=1 on the last byte; status=0001; frame_err_count=1.
- Header N=2 with input tlast after 5 payload bytes → 9 bytes out, tlast on the 9th; status=0100; err count +1.
- Header N=0 with the check byte correct but 3 extra bytes before input tlast → 5 bytes out (tlast on the check byte); the 3 extras are dropped; status=0010; the next frame parses normally.
- Back-to-back frames with m_tready toggling 1010… → no byte lost or duplicated; output bytes equal input bytes; ok count=2.
- frame_ok_count preloaded to 0xFFFE, 3 good frames → count holds at 0xFFFF. aresetn=0 mid-payload → all outputs 0, and the next frame is parsed from byte0.
